uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clk cycles per bit (50 MHz / 19200 baud); legal range 8..4095.
REQ-002 clk  input  1  50 MHz system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 RX  input  1  asynchronous serial line from the BLE module; idle high; 8N1 format, LSB first.
REQ-005 clr_rdy  input  1  consumer acknowledge; knocks down rdy.
REQ-006 cmd  output  8  last correctly framed byte received.
REQ-007 rdy  output  1  level; high while cmd holds an unconsumed byte.
REQ-008 frm_err  output  1  one-cycle pulse on a bad stop bit.

Function
REQ-009 RX SHALL pass through a 2-flop synchronizer whose flops preset to 1; all logic uses the synchronized value (rx_s).
REQ-010 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-011 In IDLE, a falling edge of rx_s (previous 1, current 0) SHALL load the baud counter with BAUD_DIV/2 (truncated) and enter START.
REQ-012 The baud counter SHALL decrement every cycle outside IDLE; the zero count is the sample point.
REQ-013 At the START sample point, rx_s=1 SHALL be treated as a false start: return to IDLE with no output change.
REQ-014 At the START sample point, rx_s=0 SHALL reload the counter with BAUD_DIV-1, clear the bit counter and enter DATA.
REQ-015 At each DATA sample point, rx_s SHALL shift into bit 7 of a 9-bit shift register (right shift) and the bit counter SHALL increment.
REQ-016 The FSM SHALL enter STOP after the 8th data sample, reloading the counter with BAUD_DIV-1.
REQ-017 At the STOP sample point with rx_s=1, the FSM SHALL take the following actions:
  - load cmd with the 8 data bits;
  - set rdy on the next edge;
  - return to IDLE.
REQ-018 At the STOP sample point with rx_s=0, the FSM SHALL pulse frm_err for exactly one cycle, leave cmd and rdy unchanged, and return to IDLE.
REQ-019 rdy SHALL clear on clr_rdy, or on the START-to-DATA transition of a new frame.
REQ-020 If a set and a clear of rdy occur in the same cycle, the set SHALL win.
REQ-021 Latency: rdy SHALL rise exactly one clk after the mid-stop-bit sample, i.e. 9.5*BAUD_DIV+3 clks after the RX falling edge (±1 for synchronizer phase).
REQ-022 Back-to-back frames (stop bit followed immediately by a start bit) SHALL be received without loss.
REQ-023 A frame arriving while rdy is high SHALL overwrite cmd; there is no overrun flag.
REQ-024 clr_rdy while rdy is low SHALL have no effect.

Reset
REQ-025 Asserting rst_n low SHALL immediately force the following values, with any in-progress frame abandoned:
  - state = IDLE; baud counter, bit counter and shift register = 0;
  - cmd = 8'h00; rdy = 0; frm_err = 0;
  - synchronizer flops = 1.
REQ-026 After rst_n deasserts, a line already low SHALL NOT start a frame; a fresh falling edge is required.

Structure
REQ-027 A shared package uart_pkg SHALL hold the rx_state_t enum (IDLE, START, DATA, STOP) and the default divisor constant BAUD_DIV_DFLT=2604.
REQ-028 The 2-flop synchronizer SHALL be a sub-module sync2 with parameter RST_VAL, reusable by the bump-switch inputs.
REQ-029 Counters SHALL be sized: baud counter 12 bits, bit counter 4 bits.

Verification (BAUD_DIV=16 unless noted)
REQ-030 Send byte 8'hA5 -> rdy rises 155±1 clks after the start edge, cmd=8'hA5, frm_err never high.
REQ-031 Send 8'h3C then 8'hC3 back-to-back with no clr_rdy -> cmd=8'h3C, then rdy drops at the second frame's START-to-DATA transition, then cmd=8'hC3 with rdy high.
REQ-032 Send 8'h55 with the stop bit held at 0 -> one frm_err pulse; cmd keeps its previous value; rdy stays low.
REQ-033 Pulse RX low for 5 clks only -> false start, FSM returns to IDLE, no rdy, no frm_err.
REQ-034 Assert rst_n low mid-DATA of 8'hFF, release, then send 8'h0F -> cmd=8'h00 and rdy=0 during reset, then cmd=8'h0F.
REQ-035 Assert clr_rdy on the same cycle rdy is being set -> rdy remains high; with BAUD_DIV=2604, byte 8'h7E is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default divisor.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int unsigned BAUD_DIV_DFLT = 2604;
  localparam int unsigned BAUD_CNT_W    = 12;
  localparam int unsigned BIT_CNT_W     = 4;
  localparam int unsigned DATA_BITS     = 8;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs; both flops reset to RST_VAL.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, byte-ready level flag and framing-error pulse.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned BAUD_DIV = BAUD_DIV_DFLT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] cmd,
  output logic       rdy,
  output logic       frm_err
);

  localparam logic [BAUD_CNT_W-1:0] HALF_LOAD = BAUD_CNT_W'(BAUD_DIV / 2);
  localparam logic [BAUD_CNT_W-1:0] BIT_LOAD  = BAUD_CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_CNT_W-1:0]  LAST_BIT  = BIT_CNT_W'(DATA_BITS - 1);

  rx_state_t             state;
  logic [BAUD_CNT_W-1:0] baud_cnt;
  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [8:0]            shreg;
  logic                  rx_s;
  logic [1:0]            sync_vld;
  logic                  rx_prev;
  logic                  rx_fall;
  logic                  sample;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (RX),
    .q     (rx_s)
  );

  // rx_prev only records a high level once the synchronizer holds real line
  // samples, so a line that is already low at reset release never looks like
  // a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_vld <= '0;
      rx_prev  <= 1'b0;
    end else begin
      sync_vld <= {sync_vld[0], 1'b1};
      rx_prev  <= rx_s & sync_vld[1];
    end
  end

  always_comb begin
    rx_fall = rx_prev & ~rx_s;
    sample  = (baud_cnt == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      cmd      <= '0;
      rdy      <= 1'b0;
      frm_err  <= 1'b0;
    end else begin
      frm_err <= 1'b0;
      // Clear first so a same-cycle set further down takes priority.
      if (clr_rdy) rdy <= 1'b0;

      case (state)
        IDLE: begin
          if (rx_fall) begin
            baud_cnt <= HALF_LOAD;
            state    <= START;
          end
        end

        START: begin
          if (sample) begin
            if (rx_s) begin
              state <= IDLE;
            end else begin
              baud_cnt <= BIT_LOAD;
              bit_cnt  <= '0;
              rdy      <= 1'b0;
              state    <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        DATA: begin
          if (sample) begin
            shreg    <= {shreg[8], rx_s, shreg[7:1]};
            bit_cnt  <= bit_cnt + 1'b1;
            baud_cnt <= BIT_LOAD;
            if (bit_cnt == LAST_BIT) state <= STOP;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        STOP: begin
          if (sample) begin
            shreg[8] <= rx_s;
            if (rx_s) begin
              cmd <= shreg[7:0];
              rdy <= 1'b1;
            end else begin
              frm_err <= 1'b1;
            end
            state <= IDLE;
          end else begin
            baud_cnt <= baud_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed scenarios plus randomized frames against a frame-level model.
module tb_uart_rx;

  localparam int unsigned DIV_F = 16;
  localparam int unsigned DIV_S = 2604;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       rx_f   = 1'b1;
  logic       clr_f  = 1'b0;
  logic       rx_sl  = 1'b1;
  logic       clr_sl = 1'b0;
  logic [7:0] cmd_f, cmd_sl;
  logic       rdy_f, rdy_sl, ferr_f, ferr_sl;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  int unsigned cyc      = 0;

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.BAUD_DIV(DIV_F)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx_f),
    .clr_rdy (clr_f),
    .cmd     (cmd_f),
    .rdy     (rdy_f),
    .frm_err (ferr_f)
  );

  uart_rx #(.BAUD_DIV(DIV_S)) dut_slow (
    .clk     (clk),
    .rst_n   (rst_n),
    .RX      (rx_sl),
    .clr_rdy (clr_sl),
    .cmd     (cmd_sl),
    .rdy     (rdy_sl),
    .frm_err (ferr_sl)
  );

  // Event monitor: rdy edges (cycle stamps) and frm_err high-cycle counts.
  logic        rdy_fq = 1'b0, rdy_sq = 1'b0;
  int unsigned rise_f = 0, fall_f = 0, nrise_f = 0, nerr_f = 0;
  int unsigned rise_s = 0, nrise_s = 0, nerr_s = 0;

  always @(negedge clk) begin
    rdy_fq <= rdy_f;
    rdy_sq <= rdy_sl;
    if (rdy_f && !rdy_fq) begin
      rise_f  <= cyc;
      nrise_f <= nrise_f + 1;
    end
    if (!rdy_f && rdy_fq) fall_f <= cyc;
    if (ferr_f) nerr_f <= nerr_f + 1;
    if (rdy_sl && !rdy_sq) begin
      rise_s  <= cyc;
      nrise_s <= nrise_s + 1;
    end
    if (ferr_sl) nerr_s <= nerr_s + 1;
  end

  // Start edge to rdy: 9.5 bit times plus 3 clocks.
  function automatic int unsigned lat_of(input int unsigned div);
    return (19 * div) / 2 + 3;
  endfunction

  // Start edge to the START-to-DATA decision: half a bit plus 3 clocks.
  function automatic int unsigned s2d_of(input int unsigned div);
    return div / 2 + 3;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    assert ((obs + 1 >= exp) && (obs <= exp + 1)) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d+-1", tag, obs, exp);
    end
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 10-bit frame; clr_at selects the frame cycle (0-based from
  // the start edge) on which clr_rdy is high, -1 for none.
  task automatic send_frame(input logic slow, input logic [7:0] b, input logic stop_bit,
                            input int clr_at, output int unsigned t0);
    int unsigned div;
    logic [9:0]  fr;
    div = slow ? DIV_S : DIV_F;
    fr  = {stop_bit, b, 1'b0};
    t0  = cyc + 1;
    for (int unsigned j = 0; j < 10 * div; j++) begin
      if (slow) begin
        rx_sl  = fr[j / div];
        clr_sl = (int'(j) == clr_at);
      end else begin
        rx_f  = fr[j / div];
        clr_f = (int'(j) == clr_at);
      end
      @(posedge clk);
      #1;
    end
    clr_f  = 1'b0;
    clr_sl = 1'b0;
    rx_f   = 1'b1;
    rx_sl  = 1'b1;
  endtask

  initial begin
    logic [7:0]  b, exp_cmd;
    logic        ok, exp_rdy, prev_ok, had_rdy, clr_gap;
    int unsigned t0, gap, n0, r0;
    int          clr_at;

    idle(3);
    check("rst_cmd", cmd_f, 8'h00);
    check("rst_rdy", rdy_f, 1'b0);
    check("rst_ferr", ferr_f, 1'b0);
    check("rst_cmd_slow", cmd_sl, 8'h00);
    check("rst_rdy_slow", rdy_sl, 1'b0);
    rst_n = 1'b1;
    idle(10);

    // Single byte: value, latency, no framing error.
    n0 = nerr_f;
    r0 = nrise_f;
    send_frame(1'b0, 8'hA5, 1'b1, -1, t0);
    check("a5_cmd", cmd_f, 8'hA5);
    check("a5_rdy", rdy_f, 1'b1);
    check("a5_rise_cnt", nrise_f - r0, 1);
    check_near("a5_latency", rise_f - t0, lat_of(DIV_F));
    check("a5_no_ferr", nerr_f - n0, 0);
    idle(5);

    // Back-to-back frames without acknowledging.
    send_frame(1'b0, 8'h3C, 1'b1, -1, t0);
    check("b2b1_cmd", cmd_f, 8'h3C);
    check("b2b1_rdy", rdy_f, 1'b1);
    check_near("b2b1_fall", fall_f - t0, s2d_of(DIV_F));
    send_frame(1'b0, 8'hC3, 1'b1, -1, t0);
    check_near("b2b2_fall", fall_f - t0, s2d_of(DIV_F));
    check("b2b2_cmd", cmd_f, 8'hC3);
    check("b2b2_rdy", rdy_f, 1'b1);
    check_near("b2b2_latency", rise_f - t0, lat_of(DIV_F));

    // Acknowledge, then acknowledge again while already low.
    clr_f = 1'b1; idle(1); clr_f = 1'b0; idle(1);
    check("clr_rdy", rdy_f, 1'b0);
    clr_f = 1'b1; idle(1); clr_f = 1'b0; idle(1);
    check("clr_low_rdy", rdy_f, 1'b0);
    check("clr_low_cmd", cmd_f, 8'hC3);

    // Bad stop bit.
    n0 = nerr_f;
    send_frame(1'b0, 8'h55, 1'b0, -1, t0);
    idle(4);
    check("ferr_pulses", nerr_f - n0, 1);
    check("ferr_cmd_kept", cmd_f, 8'hC3);
    check("ferr_rdy_low", rdy_f, 1'b0);

    // Glitch shorter than half a bit.
    n0 = nerr_f;
    r0 = nrise_f;
    rx_f = 1'b0; idle(5); rx_f = 1'b1; idle(40);
    check("glitch_rdy", rdy_f, 1'b0);
    check("glitch_cmd", cmd_f, 8'hC3);
    check("glitch_ferr", nerr_f - n0, 0);
    check("glitch_rise", nrise_f - r0, 0);

    // clr_rdy on the same edge rdy is set.
    send_frame(1'b0, 8'h81, 1'b1, int'(lat_of(DIV_F)), t0);
    check("clrset_rdy", rdy_f, 1'b1);
    check("clrset_cmd", cmd_f, 8'h81);

    // Randomized frames against a frame-level model.
    exp_cmd = 8'h81;
    exp_rdy = 1'b1;
    prev_ok = 1'b1;
    for (int unsigned k = 0; k < 16; k++) begin
      b       = 8'($urandom);
      ok      = ($urandom_range(0, 3) != 0);
      gap     = $urandom_range(0, 12);
      clr_gap = ($urandom_range(0, 3) == 0);
      clr_at  = ($urandom_range(0, 3) == 0) ? int'(lat_of(DIV_F)) : -1;
      if (!prev_ok && gap < 4) gap = 4;
      if (clr_gap) begin
        clr_f = 1'b1; idle(1); clr_f = 1'b0;
        exp_rdy = 1'b0;
      end
      idle(gap);
      had_rdy = exp_rdy;
      n0 = nerr_f;
      r0 = nrise_f;
      send_frame(1'b0, b, ok, clr_at, t0);
      if (ok) exp_cmd = b;
      exp_rdy = ok;
      check("rnd_cmd", cmd_f, exp_cmd);
      check("rnd_rdy", rdy_f, exp_rdy);
      check("rnd_ferr", nerr_f - n0, ok ? 0 : 1);
      if (ok) check_near("rnd_latency", rise_f - t0, lat_of(DIV_F));
      if (had_rdy) check_near("rnd_fall", fall_f - t0, s2d_of(DIV_F));
      prev_ok = ok;
    end
    idle(4);

    // Reset in the middle of a frame, with the line held low across release.
    send_frame(1'b0, 8'h96, 1'b1, -1, t0);
    check("pre_rst_cmd", cmd_f, 8'h96);
    rx_f = 1'b0; idle(DIV_F);
    rx_f = 1'b1; idle(40);
    rst_n = 1'b0;
    rx_f  = 1'b0;
    #1;
    check("mid_rst_cmd", cmd_f, 8'h00);
    check("mid_rst_rdy", rdy_f, 1'b0);
    check("mid_rst_ferr", ferr_f, 1'b0);
    idle(3);
    rst_n = 1'b1;
    n0 = nerr_f;
    r0 = nrise_f;
    idle(100);
    check("low_line_rdy", rdy_f, 1'b0);
    check("low_line_ferr", nerr_f - n0, 0);
    check("low_line_rise", nrise_f - r0, 0);
    rx_f = 1'b1; idle(20);
    send_frame(1'b0, 8'h0F, 1'b1, -1, t0);
    check("post_rst_cmd", cmd_f, 8'h0F);
    check("post_rst_rdy", rdy_f, 1'b1);
    check_near("post_rst_latency", rise_f - t0, lat_of(DIV_F));

    // Default divisor, clr_rdy colliding with the set edge.
    idle(10);
    n0 = nerr_s;
    send_frame(1'b1, 8'h7E, 1'b1, int'(lat_of(DIV_S)), t0);
    check("slow_cmd", cmd_sl, 8'h7E);
    check("slow_rdy", rdy_sl, 1'b1);
    check_near("slow_latency", rise_s - t0, lat_of(DIV_S));
    check("slow_ferr", nerr_s - n0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
